// File: rtl/alu_writeback_if.sv
// rtl/alu_writeback_if.sv - operation handshake bus into the ALU writeback controller
interface alu_writeback_if #(
    parameter int REG_AW = 5,
    parameter int MEM_AW = 9,
    parameter int DW     = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [5:0]        opcode;
    logic [REG_AW-1:0] rdst1;
    logic [REG_AW-1:0] rdst2;
    logic [MEM_AW-1:0] mem_addr;
    logic [2*DW-1:0]   result;

    modport master (
        output in_valid, opcode, rdst1, rdst2, mem_addr, result,
        input  in_ready
    );

    modport slave (
        input  in_valid, opcode, rdst1, rdst2, mem_addr, result,
        output in_ready
    );
endinterface

// File: rtl/alu_writeback.sv
// rtl/alu_writeback.sv - commits ALU results to register file or data memory, MUL split over two writes
module alu_writeback #(
    parameter int REG_AW = 5,
    parameter int MEM_AW = 9,
    parameter int DW     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_writeback_if.slave    op,
    input  logic              wr_hold,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DW-1:0]     rf_wdata,
    output logic              dm_we,
    output logic [MEM_AW-1:0] dm_waddr,
    output logic [DW-1:0]     dm_wdata,
    output logic              done,
    output logic              illegal
);
    typedef enum logic [1:0] {IDLE, WR1, WR2} state_t;

    localparam logic [5:0] OP_STORE = 6'b000011;
    localparam logic [5:0] OP_MUL   = 6'b000111;
    localparam logic [5:0] OP_LAST  = 6'b010000;

    state_t            state, state_nxt;
    logic              is_store_q, is_mul_q;
    logic [REG_AW-1:0] hi_addr_q;
    logic [DW-1:0]     hi_data_q;
    logic              accept, undefined;

    assign undefined = (op.opcode > OP_LAST);
    assign accept    = (state == IDLE) && op.in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (op.in_valid && !undefined) state_nxt = WR1;
            WR1:     if (!wr_hold) state_nxt = is_mul_q ? WR2 : IDLE;
            WR2:     if (!wr_hold) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes are gated by wr_hold combinationally so a hold suppresses the write in the same cycle.
    always_comb begin
        op.in_ready = (state == IDLE);
        rf_we       = 1'b0;
        dm_we       = 1'b0;
        done        = 1'b0;
        if (!wr_hold) begin
            case (state)
                WR1: begin
                    rf_we = !is_store_q;
                    dm_we = is_store_q;
                    done  = !is_mul_q;
                end
                WR2: begin
                    rf_we = 1'b1;
                    done  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            dm_waddr   <= '0;
            dm_wdata   <= '0;
            hi_addr_q  <= '0;
            hi_data_q  <= '0;
            is_store_q <= 1'b0;
            is_mul_q   <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            illegal <= accept && undefined;
            if (accept && !undefined) begin
                is_store_q <= (op.opcode == OP_STORE);
                is_mul_q   <= (op.opcode == OP_MUL);
                hi_addr_q  <= op.rdst2;
                hi_data_q  <= op.result[2*DW-1:DW];
                if (op.opcode == OP_STORE) begin
                    dm_waddr <= op.mem_addr;
                    dm_wdata <= op.result[DW-1:0];
                end else begin
                    rf_waddr <= op.rdst1;
                    rf_wdata <= op.result[DW-1:0];
                end
            end else if (state == WR1 && !wr_hold && is_mul_q) begin
                // Swap in the high half so WR2 drives registered address/data.
                rf_waddr <= hi_addr_q;
                rf_wdata <= hi_data_q;
            end
        end
    end
endmodule

// File: tb/tb_alu_writeback.sv
// tb/tb_alu_writeback.sv - directed scoreboard bench for alu_writeback
module tb_alu_writeback;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_hold;
    logic       rf_we, dm_we, done, illegal;
    logic [4:0] rf_waddr;
    logic [15:0] rf_wdata, dm_wdata;
    logic [8:0] dm_waddr;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        mem;
        logic [8:0]  addr;
        logic [15:0] data;
        logic        fin;
    } exp_t;

    exp_t sb[$];

    alu_writeback_if #(.REG_AW(5), .MEM_AW(9), .DW(16)) bus ();

    alu_writeback #(.REG_AW(5), .MEM_AW(9), .DW(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .op       (bus.slave),
        .wr_hold  (wr_hold),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .dm_we    (dm_we),
        .dm_waddr (dm_waddr),
        .dm_wdata (dm_wdata),
        .done     (done),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic mem, input logic [8:0] addr, input logic [15:0] data, input logic fin);
        exp_t e;
        e.mem = mem; e.addr = addr; e.data = data; e.fin = fin;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [5:0] opc, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [8:0] ma, input logic [31:0] res);
        bus.in_valid = 1'b1;
        bus.opcode   = opc;
        bus.rdst1    = r1;
        bus.rdst2    = r2;
        bus.mem_addr = ma;
        bus.result   = res;
        step();
        bus.in_valid = 1'b0;
        bus.opcode   = 6'h3f;
        bus.result   = 32'hdead_beef;
    endtask

    task automatic sb_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_unexpected"}, {30'd0, rf_we, dm_we}, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_rf_we"}, {31'd0, rf_we}, {31'd0, !e.mem});
        chk({tag, "_dm_we"}, {31'd0, dm_we}, {31'd0, e.mem});
        chk({tag, "_addr"}, e.mem ? {23'd0, dm_waddr} : {27'd0, rf_waddr}, {23'd0, e.addr});
        chk({tag, "_data"}, e.mem ? {16'd0, dm_wdata} : {16'd0, rf_wdata}, {16'd0, e.data});
        chk({tag, "_done"}, {31'd0, done}, {31'd0, e.fin});
    endtask

    task automatic idle_check(input string tag);
        chk({tag, "_strobes"}, {29'd0, rf_we, dm_we, done}, 32'd0);
        chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        rst_n        = 1'b0;
        wr_hold      = 1'b0;
        bus.in_valid = 1'b0;
        bus.opcode   = '0;
        bus.rdst1    = '0;
        bus.rdst2    = '0;
        bus.mem_addr = '0;
        bus.result   = '0;
        step();
        step();

        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_flags", {28'd0, rf_we, dm_we, done, illegal}, 32'd0);
        chk("rst_rf", {11'd0, rf_waddr, rf_wdata}, 32'd0);
        chk("rst_dm", {7'd0, dm_waddr, dm_wdata}, 32'd0);
        rst_n = 1'b1;
        step();

        // ADD
        push(1'b0, 9'd3, 16'h1234, 1'b1);
        issue(6'b000100, 5'd3, 5'd0, 9'd0, 32'h0000_1234);
        chk("add_in_ready", {31'd0, bus.in_ready}, 32'd0);
        sb_check("add");
        step();
        idle_check("add_after");

        // MUL split across two registers
        push(1'b0, 9'd4, 16'h0123, 1'b0);
        push(1'b0, 9'd5, 16'hABCD, 1'b1);
        issue(6'b000111, 5'd4, 5'd5, 9'd0, 32'hABCD_0123);
        sb_check("mul_lo");
        step();
        chk("mul_wr2_in_ready", {31'd0, bus.in_ready}, 32'd0);
        sb_check("mul_hi");
        step();
        idle_check("mul_after");

        // STORE to top address
        push(1'b1, 9'h1FF, 16'hBEEF, 1'b1);
        issue(6'b000011, 5'd2, 5'd0, 9'h1FF, 32'h0000_BEEF);
        sb_check("store");
        step();
        idle_check("store_after");

        // ADD held for three cycles
        wr_hold = 1'b1;
        push(1'b0, 9'd7, 16'h7777, 1'b1);
        issue(6'b000100, 5'd7, 5'd0, 9'd0, 32'h0000_7777);
        for (int i = 0; i < 3; i++) begin
            chk("hold_strobes", {29'd0, rf_we, dm_we, done}, 32'd0);
            chk("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
            chk("hold_addr_data", {11'd0, rf_waddr, rf_wdata}, {11'd0, 5'd7, 16'h7777});
            if (i < 2) step();
        end
        wr_hold = 1'b0;
        #1;
        sb_check("hold_release");
        step();
        idle_check("hold_after");

        // undefined opcode then back-to-back SUB
        issue(6'b010001, 5'd1, 5'd0, 9'd0, 32'h0000_1111);
        chk("ill_pulse", {31'd0, illegal}, 32'd1);
        idle_check("ill");
        push(1'b0, 9'd9, 16'h5555, 1'b1);
        issue(6'b000101, 5'd9, 5'd0, 9'd0, 32'h0000_5555);
        chk("ill_cleared", {31'd0, illegal}, 32'd0);
        sb_check("sub");
        step();
        idle_check("sub_after");

        // MUL with identical destinations
        push(1'b0, 9'd6, 16'h2222, 1'b0);
        push(1'b0, 9'd6, 16'h3333, 1'b1);
        issue(6'b000111, 5'd6, 5'd6, 9'd0, 32'h3333_2222);
        sb_check("mul_same_lo");
        step();
        sb_check("mul_same_hi");
        step();

        // opcode range boundaries
        push(1'b0, 9'd31, 16'hFACE, 1'b1);
        issue(6'b010000, 5'd31, 5'd0, 9'd0, 32'h0000_FACE);
        sb_check("lrsh");
        step();
        issue(6'b111111, 5'd1, 5'd0, 9'd0, 32'h0000_0001);
        chk("ill_top", {31'd0, illegal}, 32'd1);
        idle_check("ill_top");

        // reset during MUL WR1 aborts the high write
        push(1'b0, 9'd10, 16'h4444, 1'b0);
        issue(6'b000111, 5'd10, 5'd11, 9'd0, 32'h9999_4444);
        sb_check("abort_lo");
        rst_n = 1'b0;
        #1;
        chk("abort_rf_we", {31'd0, rf_we}, 32'd0);
        chk("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("abort_addr", {27'd0, rf_waddr}, 32'd0);
        step();
        chk("abort_held", {29'd0, rf_we, dm_we, done}, 32'd0);
        rst_n = 1'b1;
        step();
        idle_check("abort_after1");
        step();
        idle_check("abort_after2");

        chk("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_writeback.md
# alu_writeback

Writeback controller at the far end of the ALU datapath. It accepts one completed operation per handshake: opcode, destination fields and result. It commits the result into the register file or the data memory through single-port write strobes. The ALU and decoder read operands through the register-file read port; this block owns the register-file write port and the data-memory write port. A 32-bit MUL product is split across two destination registers over two write cycles.

## Interface
Parameters:
- REG_AW, 5, register-file address width (Rdst fields)
- MEM_AW, 9, data-memory address width (RdstAdd field)
- DW, 16, data word width

Ports:
- clk  in  1  rising-edge clock; the block's only clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  an operation is presented
- in_ready  out  1  block can accept an operation
- opcode  in  6  instruction bits [31:26]
- rdst1  in  REG_AW  primary destination register
- rdst2  in  REG_AW  secondary destination (MUL high half)
- mem_addr  in  MEM_AW  STORE target address
- result  in  2*DW  ALU result; [15:0] used except for MUL
- wr_hold  in  1  write ports busy; stall current write
- rf_we  out  1  register-file write strobe
- rf_waddr  out  REG_AW  register-file write address
- rf_wdata  out  DW  register-file write data
- dm_we  out  1  data-memory write strobe
- dm_waddr  out  MEM_AW  data-memory write address
- dm_wdata  out  DW  data-memory write data
- done  out  1  one-cycle pulse on final write of an operation
- illegal  out  1  one-cycle pulse when an undefined opcode is accepted

## Operation
- FSM states: IDLE, WR1, WR2.
- IDLE:
  - in_ready=1.
  - When in_valid=1 at a rising edge, latch opcode, rdst1, rdst2, mem_addr and result.
  - Then go to WR1, except for an undefined opcode: stay in IDLE, pulse illegal next cycle, no write.
- Opcode map for WR1:
  - 000000 MOV-imm, 000001 MOV-reg, 000010 LOAD: register write. Address rdst1, data result[15:0].
  - 000011 STORE: memory write. Address mem_addr, data result[15:0].
  - 000100..010000 (ADD, SUB, NEG, DIV, OR, XOR, NAND, NOR, XNOR, NOT, LLSH, LRSH): register write. Address rdst1, data result[15:0].
  - 000111 MUL: register write, address rdst1, data result[15:0], then WR2.
  - 010001..111111: undefined.
- WR1 → IDLE, except MUL → WR2.
- WR2: register write. Address rdst2, data result[31:16]. Then → IDLE.
- Strobe gating:
  - rf_we and dm_we are asserted only in WR1/WR2 with wr_hold=0. They are never both 1.
  - While wr_hold=1, strobes are 0, the state holds, and address/data hold.
- done=1 in the cycle the final strobe is asserted, meaning the strobe is 1 and wr_hold=0.
- MUL with rdst1==rdst2: both writes are issued; the high half is the final value.
- in_ready=0 in WR1/WR2. Inputs are ignored there.

## Timing
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE.
  - Outputs: in_ready=1; rf_we, dm_we, done and illegal = 0; all address/data outputs 0.
  - Latched operation is discarded.
  - Reset mid-WR1/WR2 aborts the remaining write(s). No strobe is asserted after rst_n falls.
- Latency: operation accepted at edge k → strobe high in cycle k..k+1, committed by the memory at edge k+1. MUL high half is committed at edge k+2.
- Throughput with no hold: 1 op / 2 cycles; MUL 1 op / 3 cycles.
- Each wr_hold cycle adds one cycle to latency.
- Address/data outputs are registered and stable for the whole strobe cycle, and during any hold.
- illegal pulses in cycle k..k+1 for an undefined opcode accepted at edge k. in_ready stays 1.

## Test plan
- Reset, then ADD: opcode=000100, rdst1=3, result=0x0000_1234, in_valid for 1 cycle → one cycle later rf_we=1, rf_waddr=3, rf_wdata=0x1234, done=1; next cycle all strobes 0, in_ready=1.
- MUL: opcode=000111, rdst1=4, rdst2=5, result=0xABCD_0123 → cycle 1: rf_we=1, addr 4, data 0x0123, done=0; cycle 2: rf_we=1, addr 5, data 0xABCD, done=1.
- STORE: opcode=000011, mem_addr=0x1FF, result=0x0000_BEEF → dm_we=1, dm_waddr=0x1FF, dm_wdata=0xBEEF, rf_we=0.
- Hold: ADD accepted with wr_hold=1 for 3 cycles → rf_we=0 and in_ready=0 for 3 cycles, then a single rf_we pulse with unchanged addr/data.
- Illegal: opcode=010001 → no strobe, illegal pulses 1 cycle, in_ready stays 1; a back-to-back SUB on the next cycle completes normally.
- Reset abort: assert rst_n=0 in MUL WR1 → rf_we drops immediately, no WR2 write, in_ready=1 after release.
